// File: rtl/nois_system_mem_stream_reader_if.sv
// Bundle of the control, memory-port and stream signals of the block reader.
// master = the reader itself, slave = the surrounding system (RAM, sink, controller).
interface nois_system_mem_stream_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  // Block request / status
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     length;
  logic                busy;
  logic                done;
  // Memory read port (fixed one-cycle read latency)
  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;
  // Output stream
  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;
  logic                st_sop;
  logic                st_eop;

  modport master (
    input  start, base_addr, length, m_readdata, st_ready,
    output busy, done, m_address, m_chipselect, m_write, m_writedata,
           m_byteenable, m_clken, st_data, st_valid, st_sop, st_eop
  );

  modport slave (
    output start, base_addr, length, m_readdata, st_ready,
    input  busy, done, m_address, m_chipselect, m_write, m_writedata,
           m_byteenable, m_clken, st_data, st_valid, st_sop, st_eop
  );
endinterface

// File: rtl/nois_system_mem_stream_reader.sv
// Block reader: streams `length` consecutive words from an on-chip RAM port
// (read latency 1) out through a small FIFO with sop/eop framing.
// Reads are only issued when the FIFO is guaranteed room for the returning word.
module nois_system_mem_stream_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  nois_system_mem_stream_reader_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [LEN_W-1:0]    r_out_idx;
  logic                r_rd_vld_p1;   // a read was issued last cycle; its data arrives now
  logic                r_zero_done;
  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_start_ok;
  logic                w_start_zero;
  logic [CNT_W-1:0]    w_occupancy;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_st_valid;
  logic                w_drain_exit;

  assign w_start_ok   = (r_state == S_IDLE) && bus.start && (bus.length != '0);
  assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.length == '0);
  // Words buffered plus the word still in flight must leave room for one more.
  assign w_occupancy  = r_count + CNT_W'(r_rd_vld_p1);
  assign w_issue      = (r_state == S_RUN) && (w_occupancy < CNT_W'(FIFO_DEPTH))
                        && (r_issued < r_len);
  assign w_last_issue = w_issue && ((r_issued + LEN_W'(1)) == r_len);
  assign w_push       = r_rd_vld_p1;
  assign w_st_valid   = (r_count != '0);
  assign w_pop        = w_st_valid && bus.st_ready;
  assign w_drain_exit = (r_state == S_DRAIN) && !r_rd_vld_p1 && !w_st_valid;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)   w_next_state = S_RUN;
      S_RUN:   if (w_last_issue) w_next_state = S_DRAIN;
      S_DRAIN: if (w_drain_exit) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: address, length, issue/output counters, read pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_out_idx   <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_issue;
      r_zero_done <= w_start_zero;
      if (w_start_ok) begin
        r_addr    <= bus.base_addr;
        r_len     <= bus.length;
        r_issued  <= '0;
        r_out_idx <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_issued <= r_issued + LEN_W'(1);
        end
        if (w_pop) r_out_idx <= r_out_idx + LEN_W'(1);
      end
    end
  end

  // FIFO pointers and fill count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage captures the word returned for last cycle's read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.m_readdata;
  end

  assign bus.busy         = (r_state != S_IDLE) && !w_drain_exit;
  assign bus.done         = w_drain_exit || r_zero_done;
  assign bus.m_address    = r_addr;
  assign bus.m_chipselect = w_issue;
  assign bus.m_write      = 1'b0;
  assign bus.m_writedata  = '0;
  assign bus.m_byteenable = '1;
  assign bus.m_clken      = 1'b1;
  assign bus.st_data      = r_fifo[r_rd_ptr];
  assign bus.st_valid     = w_st_valid;
  assign bus.st_sop       = w_st_valid && (r_out_idx == '0);
  assign bus.st_eop       = w_st_valid && (r_out_idx == (r_len - LEN_W'(1)));
endmodule

// File: doc/nois_system_mem_stream_reader.md
NOIS_SYSTEM_MEM_STREAM_READER -- requirements
Module: nois_system_mem_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, memory word-address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 16, memory/stream word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-004 SHALL have ports:
 clk  in  1  single clock for all logic
 reset_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle request to begin a block read
 base_addr  in  ADDR_W  first word address of block
 length  in  ADDR_W+1  number of words, 0..2048
 busy  out  1  transfer in progress
 done  out  1  one-cycle pulse on transfer completion
 m_address  out  ADDR_W  memory port address
 m_chipselect  out  1  memory port select (read issue)
 m_write  out  1  memory write enable, tied 0
 m_writedata  out  DATA_W  tied 0
 m_byteenable  out  DATA_W/8  tied all-ones
 m_clken  out  1  memory clock enable, tied 1
 m_readdata  in  DATA_W  memory read data
 st_data  out  DATA_W  stream data
 st_valid  out  1  stream word valid
 st_ready  in  1  sink accepts word
 st_sop  out  1  first word of block
 st_eop  out  1  last word of block

Function
REQ-005 SHALL act as a read master on one port of the dual-port on-chip RAM; m_readdata for an address issued (m_chipselect=1) in cycle N SHALL be captured in cycle N+1 (fixed latency 1, no waitrequest).
REQ-006 SHALL implement states IDLE, RUN, DRAIN.
REQ-007 IDLE: start=1 with length!=0 SHALL latch base_addr and length, enter RUN next cycle, busy=1 from that cycle.
REQ-008 IDLE: start=1 with length=0 SHALL pulse done the following cycle, stay IDLE, busy stays 0, no reads issued.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 RUN: read SHALL issue (m_chipselect=1) in any cycle where fifo_count + inflight < FIFO_DEPTH and issued < length; inflight is 1 if a read was issued the previous cycle, else 0.
REQ-011 m_address SHALL increment by 1 after each issue, wrapping 2^ADDR_W-1 -> 0.
REQ-012 When issued reaches length, SHALL go to DRAIN; no further reads.
REQ-013 DRAIN: when inflight=0 and FIFO empty, SHALL pulse done for one cycle, deassert busy that same cycle, return to IDLE.
REQ-014 Returned data SHALL enter a FIFO_DEPTH-word FIFO; FIFO SHALL never overflow (guaranteed by REQ-010); no word dropped or duplicated.
REQ-015 st_valid SHALL equal FIFO non-empty; word transfers when st_valid & st_ready; st_data SHALL hold stable while st_valid=1 and st_ready=0.
REQ-016 st_sop SHALL be 1 with the word of index 0; st_eop with word index length-1; both on same word when length=1.
REQ-017 Simultaneous FIFO push and pop SHALL keep count unchanged; pop from empty SHALL not occur.
REQ-018 With st_ready held 1, throughput SHALL be one word per cycle after first word; first st_valid SHALL occur 2 cycles after start is sampled.
REQ-019 Words SHALL be emitted in ascending address order (with wrap).

Reset
REQ-020 reset_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, m_chipselect=0, m_address=0, st_valid=0, st_sop=0, st_eop=0, FIFO empty, counters 0.
REQ-021 Reset mid-transfer SHALL discard in-flight and buffered words; no done pulse; after release the block SHALL accept a new start.

Verification
REQ-022 RAM preloaded addr=value; start, base=0x010, length=4, st_ready=1 -> st_data 0x0010..0x0013, sop on first, eop on fourth, done 1 cycle after last transfer.
REQ-023 base=0x7FE, length=4 -> reads addresses 0x7FE,0x7FF,0x000,0x001 in that order.
REQ-024 length=16, st_ready toggling 1/0 each cycle and held 0 for 10 cycles -> all 16 words delivered in order, m_chipselect never issued when FIFO+inflight=4, data stable while stalled.
REQ-025 length=0 -> done pulse next cycle, m_chipselect never 1, busy stays 0; start during busy -> ignored.
REQ-026 reset_n low after 3 of 8 words delivered -> outputs at reset values immediately; new start base=0x100 length=2 -> exactly 2 words 0x0100,0x0101 with sop/eop.
